// File: rtl/commit_scoreboard_pkg.sv
// Shared types and sizing for the commit scoreboard.
//   COMMIT_ID_WIDTH : width of a commit ID; table depth is 2**COMMIT_ID_WIDTH
//   REG_ADDR_WIDTH  : architectural register address width
//   sb_entry_t      : one tracked in-flight writer (valid bit + destination rd)
//   count_ones      : population count used by the outstanding counter
package commit_pkg;

  localparam int COMMIT_ID_WIDTH = 3;
  localparam int REG_ADDR_WIDTH  = 5;
  localparam int SB_DEPTH        = 2 ** COMMIT_ID_WIDTH;

  typedef logic [COMMIT_ID_WIDTH-1:0] commit_id_t;
  typedef logic [COMMIT_ID_WIDTH:0]   sb_cnt_t;
  typedef logic [REG_ADDR_WIDTH-1:0]  reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
  } sb_entry_t;

  function automatic sb_cnt_t count_ones(input logic [SB_DEPTH-1:0] vec);
    sb_cnt_t n;
    n = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      n = n + sb_cnt_t'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/commit_scoreboard_if.sv
// Bundle between decode / write-back (master) and the commit scoreboard (slave).
//   issue_*        : instruction presented by decode, ready/ID returned
//   commit_*       : port 1 (LSU/ALU) completion, commit_*2 port 2 (MUL/DIV/CSR)
//   flush_i        : drop every outstanding entry
//   outstanding_cnt_o / busy_o / err_o : status back to the pipeline
interface commit_scoreboard_if;
  import commit_pkg::*;

  logic       issue_valid_i;
  logic       issue_we_i;
  reg_addr_t  issue_rd_i;
  logic       issue_rs1_re_i;
  reg_addr_t  issue_rs1_i;
  logic       issue_rs2_re_i;
  reg_addr_t  issue_rs2_i;
  logic       issue_ready_o;
  commit_id_t issue_commit_id_o;
  logic       commit_valid_i;
  commit_id_t commit_id_i;
  logic       commit_valid2_i;
  commit_id_t commit_id2_i;
  logic       flush_i;
  sb_cnt_t    outstanding_cnt_o;
  logic       busy_o;
  logic       err_o;

  modport master (
    output issue_valid_i, issue_we_i, issue_rd_i,
    output issue_rs1_re_i, issue_rs1_i, issue_rs2_re_i, issue_rs2_i,
    input  issue_ready_o, issue_commit_id_o,
    output commit_valid_i, commit_id_i, commit_valid2_i, commit_id2_i,
    output flush_i,
    input  outstanding_cnt_o, busy_o, err_o
  );

  modport slave (
    input  issue_valid_i, issue_we_i, issue_rd_i,
    input  issue_rs1_re_i, issue_rs1_i, issue_rs2_re_i, issue_rs2_i,
    output issue_ready_o, issue_commit_id_o,
    input  commit_valid_i, commit_id_i, commit_valid2_i, commit_id2_i,
    input  flush_i,
    output outstanding_cnt_o, busy_o, err_o
  );
endinterface

// File: rtl/commit_scoreboard_free_id_picker.sv
// Lowest-free-ID priority encoder over the scoreboard valid vector.
//   valid_vec_i : one bit per table entry, 1 = occupied
//   free_id_o   : lowest index whose valid bit is 0 (0 when full, unused then)
//   full_o      : every entry occupied
module free_id_picker
  import commit_pkg::*;
(
  input  logic [SB_DEPTH-1:0] valid_vec_i,
  output commit_id_t          free_id_o,
  output logic                full_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    free_id_o = '0;
    for (int i = SB_DEPTH - 1; i >= 0; i--) begin
      if (!valid_vec_i[i]) begin
        free_id_o = commit_id_t'(i);
      end
    end
  end

  assign full_o = &valid_vec_i;

endmodule

// File: rtl/commit_scoreboard.sv
// Issue-side tracker for in-flight register-writing instructions.
// Allocates a commit ID per writer, stalls issue on RAW/WAW hazards or a full
// table, and retires entries from two independent commit ports.
//   clk, rst_n : clock, asynchronous active-low reset
//   sb         : scoreboard bundle (slave side), see commit_scoreboard_if
module commit_scoreboard
  import commit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  commit_scoreboard_if.slave sb
);

  sb_entry_t table_q [SB_DEPTH];
  sb_entry_t table_d [SB_DEPTH];
  sb_cnt_t   cnt_q, cnt_d;
  logic      err_q, err_d;

  logic [SB_DEPTH-1:0] valid_vec;
  logic [SB_DEPTH-1:0] clr_vec;   // valid entries retired by either port this cycle
  logic [SB_DEPTH-1:0] live_vec;  // entries that still guard hazards this cycle
  logic [SB_DEPTH-1:0] rs1_hit, rs2_hit, rd_hit;

  commit_id_t free_id;
  logic       full;
  logic       alloc, raw, waw, ready, accept_alloc, bad_commit;

  genvar gi;
  generate
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_entry
      assign valid_vec[gi] = table_q[gi].valid;
      // Both ports naming the same entry collapse into a single clear.
      assign clr_vec[gi]   = table_q[gi].valid &&
                             ((sb.commit_valid_i  && sb.commit_id_i  == commit_id_t'(gi)) ||
                              (sb.commit_valid2_i && sb.commit_id2_i == commit_id_t'(gi)));
      // Committing entries are masked: the register file writes through in
      // the commit cycle, so a reader issued now already sees the new value.
      assign live_vec[gi]  = valid_vec[gi] && !clr_vec[gi];
      assign rs1_hit[gi]   = live_vec[gi] && (table_q[gi].rd == sb.issue_rs1_i);
      assign rs2_hit[gi]   = live_vec[gi] && (table_q[gi].rd == sb.issue_rs2_i);
      assign rd_hit[gi]    = live_vec[gi] && (table_q[gi].rd == sb.issue_rd_i);
    end
  endgenerate

  // Free ID comes from the registered vector, so an entry freed this cycle is
  // never re-allocated in the same cycle it is being committed.
  free_id_picker u_free_id_picker (
    .valid_vec_i (valid_vec),
    .free_id_o   (free_id),
    .full_o      (full)
  );

  assign alloc = sb.issue_we_i && (sb.issue_rd_i != '0);
  assign raw   = (sb.issue_rs1_re_i && (sb.issue_rs1_i != '0) && (|rs1_hit)) ||
                 (sb.issue_rs2_re_i && (sb.issue_rs2_i != '0) && (|rs2_hit));
  assign waw   = alloc && (|rd_hit);
  // Ready deliberately ignores issue_valid_i so decode can use it as a stall.
  assign ready = !sb.flush_i && !raw && !waw && !(alloc && full);

  assign accept_alloc = sb.issue_valid_i && ready && alloc;

  // A commit naming an idle entry is a protocol error from the write-back side.
  assign bad_commit = (sb.commit_valid_i  && !table_q[sb.commit_id_i].valid) ||
                      (sb.commit_valid2_i && !table_q[sb.commit_id2_i].valid);

  always_comb begin
    table_d = table_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (sb.flush_i) begin
      // Flush swallows same-cycle commits and issues, including their errors.
      for (int i = 0; i < SB_DEPTH; i++) begin
        table_d[i].valid = 1'b0;
      end
      cnt_d = '0;
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (clr_vec[i]) begin
          table_d[i].valid = 1'b0;
        end
      end
      if (accept_alloc) begin
        table_d[free_id].valid = 1'b1;
        table_d[free_id].rd    = sb.issue_rd_i;
      end
      cnt_d = cnt_q + sb_cnt_t'(accept_alloc) - count_ones(clr_vec);
      err_d = err_q || bad_commit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        table_q[i] <= '0;
      end
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      table_q <= table_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign sb.issue_ready_o     = ready;
  assign sb.issue_commit_id_o = free_id;
  assign sb.outstanding_cnt_o = cnt_q;
  assign sb.busy_o            = (cnt_q != '0);
  assign sb.err_o             = err_q;

endmodule

// File: doc/commit_scoreboard.md
Name: commit_scoreboard

Overview:
- Issue-side tracker for all in-flight register-writing instructions; it is the consumer of the dual-port commit stream driven by the write-back unit.
- Allocates a commit ID per issued register-writing instruction and records its destination register.
- Stalls issue on RAW/WAW hazards or when the table is full.
- Retires entries on commit_valid/commit_id (port 1: LSU/ALU) and commit_valid2/commit_id2 (port 2: MUL/DIV/CSR).

Parameters:
- COMMIT_ID_WIDTH, 3, commit ID width; table depth = 2**COMMIT_ID_WIDTH (8).
- REG_ADDR_WIDTH, 5, architectural register address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid_i  in  1  decode presents an instruction.
- issue_we_i  in  1  instruction writes rd.
- issue_rd_i  in  REG_ADDR_WIDTH  destination register.
- issue_rs1_re_i  in  1  rs1 is read.
- issue_rs1_i  in  REG_ADDR_WIDTH  source register 1.
- issue_rs2_re_i  in  1  rs2 is read.
- issue_rs2_i  in  REG_ADDR_WIDTH  source register 2.
- issue_ready_o  out  1  issue accepted this cycle if issue_valid_i is high.
- issue_commit_id_o  out  COMMIT_ID_WIDTH  ID allocated to the current issue.
- commit_valid_i  in  1  port-1 completion.
- commit_id_i  in  COMMIT_ID_WIDTH  port-1 completed ID.
- commit_valid2_i  in  1  port-2 completion.
- commit_id2_i  in  COMMIT_ID_WIDTH  port-2 completed ID.
- flush_i  in  1  pipeline flush; discard all outstanding entries.
- outstanding_cnt_o  out  COMMIT_ID_WIDTH+1  number of valid entries.
- busy_o  out  1  outstanding_cnt_o != 0.
- err_o  out  1  sticky: commit received for a non-valid entry.

Behaviour:
- State: per entry, a valid bit and an rd field. Reset clears all valid bits; outstanding_cnt_o=0, busy_o=0, err_o=0. issue_commit_id_o resets to 0, the lowest free ID.
- Allocation need: alloc = issue_we_i && issue_rd_i != 0. Instructions with no rd write are issued without allocation; issue_commit_id_o is don't-care for them.
- Free ID: lowest-index entry whose valid bit is 0, evaluated on the registered (pre-commit) vector. Entries freed this cycle become allocatable from the next cycle.
- full = all entries valid.
- Hazard vector: entries that are valid and not being committed this cycle by either port. Masking committing entries is correct because the register file performs write-through in the same cycle as commit.
  - RAW: rsN_re && rsN != 0 && rsN matches rd of any entry in the hazard vector.
  - WAW: alloc && issue_rd_i matches rd of any entry in the hazard vector.
- issue_ready_o = !flush_i && !RAW && !WAW && !(alloc && full). It is combinational and must not depend on issue_valid_i.
- Accept: issue_valid_i && issue_ready_o at the clock edge. If alloc, entry[issue_commit_id_o] becomes valid with rd=issue_rd_i from the next cycle. Issue-to-tracked latency is 1 cycle.
- Commit: each valid commit port clears the addressed entry at the edge.
  - Both ports carrying the same ID: the entry is cleared once and no error is raised.
  - Commit to an entry that is not valid: ignored, and err_o is set until reset.
  - Commit to an entry while a new allocation targets a different ID: both take effect.
  - Allocation never targets a committing entry, because allocation uses the pre-commit free vector.
- Counter: outstanding_cnt_o += accepted alloc, minus the number of distinct valid entries cleared. It is a register updated each edge and never wraps (max 2**COMMIT_ID_WIDTH).
- Flush: at the edge with flush_i=1, all valid bits and outstanding_cnt_o go to 0. Commits and issues in that same cycle are ignored, and err_o is not set by them. Commits arriving after a flush for stale IDs set err_o; the system flushes the write-back unit simultaneously.
- Asynchronous reset mid-operation drops all entries immediately.

Decomposition:
- Shared package commit_pkg holds:
  - typedef sb_entry_t (valid, rd);
  - localparam SB_DEPTH;
  - typedef commit_id_t.
- One sub-module, free_id_picker: priority encoder over the inverted valid vector, outputting the lowest free ID and a full flag.

Test Plan:
- Reset, then issue we=1 rd=5 → issue_commit_id_o=0 and cnt=1 next cycle. Then issue rs1_re=1 rs1=5 → issue_ready_o=0. Then assert commit_valid_i with id=0 → issue_ready_o=1 in that same cycle, and cnt=0 after the edge.
- Issue 8 writers to rd=1..8 → IDs 0..7 and cnt=8. A 9th writer (rd=9) → ready=0. A non-writer with no hazards → ready=1.
- Out-of-order dual commit: outstanding IDs 2 and 5. commit_id_i=5 and commit_id2_i=2 in the same cycle → both entries cleared, cnt decreases by 2, err_o=0. Next alloc gets ID 0, the lowest free.
- Same ID on both ports (3, 3) → cleared once, cnt decreases by 1, err_o stays 0. A later commit of ID 3 → err_o=1, held until reset.
- WAW: rd=7 outstanding with ID 1, issue we=1 rd=7 → ready=0. rd=0 writer and rs1=0 reads → never stall.
- flush_i with 4 outstanding plus a simultaneous issue and commit → ready=0 during flush, cnt=0 next cycle, no entries valid, err_o unchanged. Assert rst_n low mid-run → cnt=0 and busy_o=0 immediately.
